// File: rtl/traffic_phase_ctrl.sv
// Phase-sequencing FSM of the traffic controller: loads the Timer, waits for a qualified expiry, drives lamps.
// Optional pedestrian phase (walk_pending latch, WALK state, walk_lamp) is compiled in with `define WALK_EN.
module traffic_phase_ctrl #(
  parameter logic [3:0] T_BASE = 4'd6,
  parameter logic [3:0] T_EXT  = 4'd3,
  parameter logic [3:0] T_YEL  = 4'd2,
  parameter logic [3:0] T_RED  = 4'd1,
  parameter logic [3:0] T_WALK = 4'd4
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       sensor,
  input  logic       walk_req,
  input  logic       expired,
  output logic       start_timer,
  output logic [3:0] input_value,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_lamp,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_GRN = 3'd0,
    MAIN_YEL = 3'd1,
    ALL_RED1 = 3'd2,
    SIDE_GRN = 3'd3,
    SIDE_YEL = 3'd4,
    ALL_RED2 = 3'd5,
    WALK     = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_t     state, state_nx;
  logic       load_due;      // entry load still owed for the reset state
  logic [1:0] age;           // cycles since the last load, saturating at 2
  logic       ext_used, ext_used_nx;
  logic       walk_pending;
  logic       qualified;
  logic       start_nx;
  logic [3:0] value_nx;

  function automatic logic [3:0] entry_load(input state_t s);
    case (s)
      MAIN_GRN, SIDE_GRN: entry_load = T_BASE;
      MAIN_YEL, SIDE_YEL: entry_load = T_YEL;
      WALK:               entry_load = T_WALK;
      default:            entry_load = T_RED;
    endcase
  endfunction

  function automatic logic [2:0] main_of(input state_t s);
    case (s)
      MAIN_GRN: main_of = LAMP_G;
      MAIN_YEL: main_of = LAMP_Y;
      default:  main_of = LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] side_of(input state_t s);
    case (s)
      SIDE_GRN: side_of = LAMP_G;
      SIDE_YEL: side_of = LAMP_Y;
      default:  side_of = LAMP_R;
    endcase
  endfunction

  // The Timer may still show the previous expiry during the load cycle and the one after it.
  assign qualified = !load_due && (age == 2'd2) && expired;

  // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    state_nx    = state;
    ext_used_nx = ext_used;
    start_nx    = 1'b0;
    value_nx    = input_value;
    if (load_due) begin
      start_nx = 1'b1;
      value_nx = entry_load(state);
    end else if (qualified) begin
      start_nx = 1'b1;
      case (state)
        MAIN_GRN: if (sensor || walk_pending) state_nx = MAIN_YEL;
        MAIN_YEL: state_nx = ALL_RED1;
        ALL_RED1: state_nx = walk_pending ? WALK : SIDE_GRN;
        SIDE_GRN: begin
          if (sensor && !ext_used) ext_used_nx = 1'b1;
          else                     state_nx    = SIDE_YEL;
        end
        SIDE_YEL: state_nx = ALL_RED2;
        ALL_RED2: state_nx = MAIN_GRN;
`ifdef WALK_EN
        WALK:     state_nx = sensor ? SIDE_GRN : ALL_RED2;
`endif
        default:  state_nx = ALL_RED2;
      endcase
      if (state == SIDE_GRN && state_nx == SIDE_GRN) begin
        value_nx = T_EXT;
      end else begin
        value_nx = entry_load(state_nx);
        if (state_nx == SIDE_GRN) ext_used_nx = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      state       <= ALL_RED2;
      load_due    <= 1'b1;
      age         <= 2'd0;
      ext_used    <= 1'b0;
      start_timer <= 1'b0;
      input_value <= 4'd0;
      main_lights <= LAMP_R;
      side_lights <= LAMP_R;
    end else begin
      state       <= state_nx;
      load_due    <= 1'b0;
      ext_used    <= ext_used_nx;
      start_timer <= start_nx;
      input_value <= value_nx;
      main_lights <= main_of(state_nx);
      side_lights <= side_of(state_nx);
      if (start_nx)            age <= 2'd0;
      else if (age != 2'd2)    age <= age + 2'd1;
    end
  end

`ifdef WALK_EN
  // A request arriving in the first WALK cycle is absorbed by the clear.
  always_ff @(posedge clk) begin
    if (sys_reset) begin
      walk_pending <= 1'b0;
      walk_lamp    <= 1'b0;
    end else begin
      if (state == WALK && start_timer) walk_pending <= 1'b0;
      else if (walk_req)                walk_pending <= 1'b1;
      walk_lamp <= (state_nx == WALK);
    end
  end
`else
  logic unused_walk_req;
  assign unused_walk_req = walk_req;
  assign walk_pending    = 1'b0;
  assign walk_lamp       = 1'b0;
`endif

  assign phase = state;

endmodule
